// File: rtl/stack_ctrl.sv
// -----------------------------------------------------------------------------
// stack_ctrl
//
// Stack access sequencer. Turns push / pop / set-SP requests from the control
// unit into stack-memory transactions and SP update commands for the
// downstream stack-pointer register. The stack is empty-ascending: SP points
// at the next free slot. Push writes mem[SP] then increments SP. Pop reads
// mem[SP-1] then decrements SP.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   op_valid/op_ready request handshake (accepted when both high)
//   op_code           00 nop, 01 push, 10 pop, 11 set SP
//   op_data           push data (low DATA_W bits) or new SP value
//   done, err         one-cycle completion pulse with status
//                     (00 ok, 01 overflow, 10 underflow/range, 11 mem timeout)
//   pop_data          last popped word, held until the next pop completes
//   sp_in             current SP from the SP register
//   sp_drive, sp_set  SP command (00 hold, 01 inc, 10 dec, 11 load) and value
//   mem_*             single-outstanding memory request, held until mem_ack
// -----------------------------------------------------------------------------
module stack_ctrl #(
    parameter int          DATA_W      = 32,
    parameter logic [31:0] STACK_BASE  = 32'd0,
    parameter logic [31:0] STACK_LIMIT = 32'd255,
    parameter int          TIMEOUT     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [1:0]        op_code,
    input  logic [31:0]       op_data,
    output logic              op_ready,
    output logic              done,
    output logic [1:0]        err,
    output logic [DATA_W-1:0] pop_data,
    input  logic [31:0]       sp_in,
    output logic [1:0]        sp_drive,
    output logic [31:0]       sp_set,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MEM  = 2'd1;
    localparam logic [1:0] ST_UPD  = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_SET  = 2'b11;

    localparam logic [1:0] SP_HOLD = 2'b00;
    localparam logic [1:0] SP_INC  = 2'b01;
    localparam logic [1:0] SP_DEC  = 2'b10;
    localparam logic [1:0] SP_LOAD = 2'b11;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_OVF   = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;

    localparam int             CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [31:0]    SP_SPAN   = STACK_LIMIT - STACK_BASE;

    logic [1:0]        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_ready_q, op_ready_d;
    logic              done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic [DATA_W-1:0] pop_data_q, pop_data_d;
    logic [1:0]        sp_drive_q, sp_drive_d;
    logic [31:0]       sp_set_q, sp_set_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              set_in_range;
    logic [CNT_W-1:0]  cnt_inc;

    // Offsetting by STACK_BASE makes any value below the base wrap to a huge
    // number, so one unsigned compare covers both ends of the legal range.
    assign set_in_range = (op_data - STACK_BASE) <= SP_SPAN;
    assign cnt_inc      = cnt_q + CNT_W'(1);

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        err_d       = err_q;
        pop_data_d  = pop_data_q;
        sp_drive_d  = SP_HOLD;
        sp_set_d    = sp_set_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (op_valid && op_ready_q) begin
                    op_d  = op_code;
                    cnt_d = '0;
                    case (op_code)
                        OP_PUSH: begin
                            if (sp_in == STACK_LIMIT) begin
                                state_d = ST_FIN;
                                done_d  = 1'b1;
                                err_d   = ERR_OVF;
                            end else begin
                                state_d     = ST_MEM;
                                mem_req_d   = 1'b1;
                                mem_we_d    = 1'b1;
                                mem_addr_d  = sp_in;
                                mem_wdata_d = op_data[DATA_W-1:0];
                            end
                        end
                        OP_POP: begin
                            if (sp_in == STACK_BASE) begin
                                state_d = ST_FIN;
                                done_d  = 1'b1;
                                err_d   = ERR_RANGE;
                            end else begin
                                state_d    = ST_MEM;
                                mem_req_d  = 1'b1;
                                mem_we_d   = 1'b0;
                                mem_addr_d = sp_in - 32'd1;
                            end
                        end
                        OP_SET: begin
                            done_d = 1'b1;
                            if (set_in_range) begin
                                state_d    = ST_UPD;
                                err_d      = ERR_OK;
                                sp_set_d   = op_data;
                                sp_drive_d = SP_LOAD;
                            end else begin
                                state_d = ST_FIN;
                                err_d   = ERR_RANGE;
                            end
                        end
                        default: ; // nop: accepted and dropped silently
                    endcase
                end
            end

            ST_MEM: begin
                if (mem_ack) begin
                    mem_req_d  = 1'b0;
                    state_d    = ST_UPD;
                    done_d     = 1'b1;
                    err_d      = ERR_OK;
                    if (op_q == OP_POP) begin
                        pop_data_d = mem_rdata;
                        sp_drive_d = SP_DEC;
                    end else begin
                        sp_drive_d = SP_INC;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT_C) begin
                        mem_req_d = 1'b0;
                        state_d   = ST_FIN;
                        done_d    = 1'b1;
                        err_d     = ERR_TMO;
                    end
                end
            end

            // done/err/sp_drive were registered on the way in, so both
            // completion states only need to return to IDLE after one cycle.
            ST_UPD:  state_d = ST_IDLE;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        op_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= 2'b00;
            cnt_q       <= '0;
            op_ready_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= ERR_OK;
            pop_data_q  <= '0;
            sp_drive_q  <= SP_HOLD;
            sp_set_q    <= 32'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            op_ready_q  <= op_ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            pop_data_q  <= pop_data_d;
            sp_drive_q  <= sp_drive_d;
            sp_set_q    <= sp_set_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign op_ready  = op_ready_q;
    assign done      = done_q;
    assign err       = err_q;
    assign pop_data  = pop_data_q;
    assign sp_drive  = sp_drive_q;
    assign sp_set    = sp_set_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
